// File: rtl/axil_nway_router.sv
`default_nettype none
// ============================================================================
// Module      : axil_nway_router
// Description : AXI-Lite 1-to-NUM_M address router. Each AW/AR is decoded
//               against per-port base/size windows and forwarded with the
//               window offset removed. Unmapped accesses return DECERR,
//               stalled slaves return SLVERR after TIMEOUT cycles; both are
//               counted. One write and one read outstanding, independently.
// Revision    : 1.0 - initial release
// ============================================================================
module axil_nway_router #(
    parameter int                        NUM_M   = 4,
    parameter int                        ADDR_W  = 15,
    parameter logic [NUM_M*ADDR_W-1:0]   M_BASE  = {15'h0200, 15'h0100, 15'h0080, 15'h0000},
    parameter logic [NUM_M*ADDR_W-1:0]   M_SIZE  = {15'h7E00, 15'h0100, 15'h0080, 15'h0080},
    parameter int                        TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic [ADDR_W-1:0]            s_axi_awaddr,
    input  logic                         s_axi_awvalid,
    output logic                         s_axi_awready,
    input  logic [31:0]                  s_axi_wdata,
    input  logic [3:0]                   s_axi_wstrb,
    input  logic                         s_axi_wvalid,
    output logic                         s_axi_wready,
    output logic [1:0]                   s_axi_bresp,
    output logic                         s_axi_bvalid,
    input  logic                         s_axi_bready,
    input  logic [ADDR_W-1:0]            s_axi_araddr,
    input  logic                         s_axi_arvalid,
    output logic                         s_axi_arready,
    output logic [31:0]                  s_axi_rdata,
    output logic [1:0]                   s_axi_rresp,
    output logic                         s_axi_rvalid,
    input  logic                         s_axi_rready,
    output logic [NUM_M*ADDR_W-1:0]      m_axi_awaddr,
    output logic [NUM_M-1:0]             m_axi_awvalid,
    input  logic [NUM_M-1:0]             m_axi_awready,
    output logic [NUM_M*32-1:0]          m_axi_wdata,
    output logic [NUM_M*4-1:0]           m_axi_wstrb,
    output logic [NUM_M-1:0]             m_axi_wvalid,
    input  logic [NUM_M-1:0]             m_axi_wready,
    input  logic [NUM_M*2-1:0]           m_axi_bresp,
    input  logic [NUM_M-1:0]             m_axi_bvalid,
    output logic [NUM_M-1:0]             m_axi_bready,
    output logic [NUM_M*ADDR_W-1:0]      m_axi_araddr,
    output logic [NUM_M-1:0]             m_axi_arvalid,
    input  logic [NUM_M-1:0]             m_axi_arready,
    input  logic [NUM_M*32-1:0]          m_axi_rdata,
    input  logic [NUM_M*2-1:0]           m_axi_rresp,
    input  logic [NUM_M-1:0]             m_axi_rvalid,
    output logic [NUM_M-1:0]             m_axi_rready,
    output logic [7:0]                   err_decode_cnt,
    output logic [7:0]                   err_timeout_cnt
);

    localparam int c_IDX_W   = (NUM_M > 1) ? $clog2(NUM_M) : 1;
    localparam int c_TO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int c_TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
    localparam int c_DEC_W   = 1 + c_IDX_W + ADDR_W;

    localparam logic [2:0] W_IDLE  = 3'd0;
    localparam logic [2:0] W_DATA  = 3'd1;
    localparam logic [2:0] W_FWD   = 3'd2;
    localparam logic [2:0] W_WAITB = 3'd3;
    localparam logic [2:0] W_BRSP  = 3'd4;

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_FWD   = 2'd1;
    localparam logic [1:0] R_WAITR = 2'd2;
    localparam logic [1:0] R_RRSP  = 2'd3;

    // Window decode done one bit wider than the address so base+size never wraps;
    // the loop runs high to low so the lowest matching port wins.
    function automatic logic [c_DEC_W-1:0] f_decode(input logic [ADDR_W-1:0] addr);
        logic               hit;
        logic [c_IDX_W-1:0] idx;
        logic [ADDR_W-1:0]  off;
        logic [ADDR_W:0]    base;
        logic [ADDR_W:0]    size;
        logic [ADDR_W:0]    diff;
        hit = 1'b0;
        idx = '0;
        off = '0;
        for (int i = NUM_M - 1; i >= 0; i--) begin
            base = {1'b0, M_BASE[i*ADDR_W +: ADDR_W]};
            size = {1'b0, M_SIZE[i*ADDR_W +: ADDR_W]};
            diff = {1'b0, addr} - base;
            if (({1'b0, addr} >= base) && (diff < size)) begin
                hit = 1'b1;
                idx = c_IDX_W'(i);
                off = diff[ADDR_W-1:0];
            end
        end
        return {hit, idx, off};
    endfunction

    // Saturating add of up to two events to an 8-bit error counter.
    function automatic logic [7:0] f_sat_add(input logic [7:0] cnt, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, cnt} + {7'b0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    logic                r_run;
    logic [2:0]          r_wr_st;
    logic [c_IDX_W-1:0]  r_wsel;
    logic                r_w_hit;
    logic [ADDR_W-1:0]   r_aw_off;
    logic [31:0]         r_wdata;
    logic [3:0]          r_wstrb;
    logic                r_aw_done;
    logic                r_w_done;
    logic [c_TO_W-1:0]   r_wcnt;
    logic [1:0]          r_bresp;
    logic [1:0]          r_rd_st;
    logic [c_IDX_W-1:0]  r_rsel;
    logic [ADDR_W-1:0]   r_ar_off;
    logic [c_TO_W-1:0]   r_rcnt;
    logic [31:0]         r_rdata;
    logic [1:0]          r_rresp;
    logic [7:0]          r_dec_cnt;
    logic [7:0]          r_to_cnt;

    logic                w_aw_hit;
    logic [c_IDX_W-1:0]  w_aw_idx;
    logic [ADDR_W-1:0]   w_aw_off;
    logic                w_ar_hit;
    logic [c_IDX_W-1:0]  w_ar_idx;
    logic [ADDR_W-1:0]   w_ar_off;
    logic                w_aw_hs;
    logic                w_ar_hs;
    logic                w_aw_ok;
    logic                w_w_ok;
    logic                w_w_tmo;
    logic                w_r_tmo;
    logic                w_wr_dec;
    logic                w_rd_dec;
    logic                w_wr_to;
    logic                w_rd_to;

    assign {w_aw_hit, w_aw_idx, w_aw_off} = f_decode(s_axi_awaddr);
    assign {w_ar_hit, w_ar_idx, w_ar_off} = f_decode(s_axi_araddr);

    assign s_axi_awready = r_run && (r_wr_st == W_IDLE);
    assign s_axi_wready  = (r_wr_st == W_DATA);
    assign s_axi_bvalid  = (r_wr_st == W_BRSP);
    assign s_axi_bresp   = r_bresp;
    assign s_axi_arready = r_run && (r_rd_st == R_IDLE);
    assign s_axi_rvalid  = (r_rd_st == R_RRSP);
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;
    assign err_decode_cnt  = r_dec_cnt;
    assign err_timeout_cnt = r_to_cnt;

    assign w_aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_ar_hs = s_axi_arvalid && s_axi_arready;
    assign w_aw_ok = r_aw_done || m_axi_awready[r_wsel];
    assign w_w_ok  = r_w_done  || m_axi_wready[r_wsel];
    assign w_w_tmo = (TIMEOUT != 0) && (r_wcnt == c_TO_W'(c_TO_LAST));
    assign w_r_tmo = (TIMEOUT != 0) && (r_rcnt == c_TO_W'(c_TO_LAST));

    // Error events are qualified so a response arriving on the timeout cycle still wins.
    assign w_wr_dec = (r_wr_st == W_DATA) && s_axi_wvalid && !r_w_hit;
    assign w_rd_dec = w_ar_hs && !w_ar_hit;
    assign w_wr_to  = w_w_tmo && (((r_wr_st == W_FWD) && !(w_aw_ok && w_w_ok)) ||
                                  ((r_wr_st == W_WAITB) && !m_axi_bvalid[r_wsel]));
    assign w_rd_to  = w_r_tmo && (((r_rd_st == R_FWD) && !m_axi_arready[r_rsel]) ||
                                  ((r_rd_st == R_WAITR) && !m_axi_rvalid[r_rsel]));

    // Per-port views: only the selected port ever sees valid/ready or a non-zero payload.
    for (genvar i = 0; i < NUM_M; i++) begin : g_port
        localparam logic [c_IDX_W-1:0] c_ID = c_IDX_W'(i);
        logic w_wfwd;
        logic w_rfwd;
        assign w_wfwd = (r_wr_st == W_FWD) && (r_wsel == c_ID);
        assign w_rfwd = (r_rd_st == R_FWD) && (r_rsel == c_ID);
        assign m_axi_awaddr[i*ADDR_W +: ADDR_W] = w_wfwd ? r_aw_off : '0;
        assign m_axi_awvalid[i]                 = w_wfwd && !r_aw_done;
        assign m_axi_wdata[i*32 +: 32]          = w_wfwd ? r_wdata : '0;
        assign m_axi_wstrb[i*4 +: 4]            = w_wfwd ? r_wstrb : '0;
        assign m_axi_wvalid[i]                  = w_wfwd && !r_w_done;
        assign m_axi_bready[i]                  = (r_wr_st == W_WAITB) && (r_wsel == c_ID);
        assign m_axi_araddr[i*ADDR_W +: ADDR_W] = w_rfwd ? r_ar_off : '0;
        assign m_axi_arvalid[i]                 = w_rfwd;
        assign m_axi_rready[i]                  = (r_rd_st == R_WAITR) && (r_rsel == c_ID);
    end

    // Holds the slave-side readies low while in reset and for the first cycle after.
    always_ff @(posedge clk) begin
        if (!rstn) r_run <= 1'b0;
        else       r_run <= 1'b1;
    end

    // Write channel FSM: address, data, forward, wait for B, respond.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_wr_st   <= W_IDLE;
            r_wsel    <= '0;
            r_w_hit   <= 1'b0;
            r_aw_off  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_wcnt    <= '0;
            r_bresp   <= 2'b00;
        end else begin
            case (r_wr_st)
                W_IDLE: if (w_aw_hs) begin
                    r_w_hit  <= w_aw_hit;
                    r_wsel   <= w_aw_idx;
                    r_aw_off <= w_aw_off;
                    r_wr_st  <= W_DATA;
                end
                W_DATA: if (s_axi_wvalid) begin
                    r_wdata   <= s_axi_wdata;
                    r_wstrb   <= s_axi_wstrb;
                    r_aw_done <= 1'b0;
                    r_w_done  <= 1'b0;
                    r_wcnt    <= '0;
                    if (r_w_hit) begin
                        r_wr_st <= W_FWD;
                    end else begin
                        r_bresp <= 2'b11;
                        r_wr_st <= W_BRSP;
                    end
                end
                W_FWD: begin
                    r_wcnt    <= r_wcnt + 1'b1;
                    r_aw_done <= w_aw_ok;
                    r_w_done  <= w_w_ok;
                    if (w_aw_ok && w_w_ok) begin
                        r_wr_st <= W_WAITB;
                    end else if (w_wr_to) begin
                        r_bresp <= 2'b10;
                        r_wr_st <= W_BRSP;
                    end
                end
                W_WAITB: begin
                    r_wcnt <= r_wcnt + 1'b1;
                    if (m_axi_bvalid[r_wsel]) begin
                        r_bresp <= m_axi_bresp[{r_wsel, 1'b0} +: 2];
                        r_wr_st <= W_BRSP;
                    end else if (w_wr_to) begin
                        r_bresp <= 2'b10;
                        r_wr_st <= W_BRSP;
                    end
                end
                W_BRSP: if (s_axi_bready) r_wr_st <= W_IDLE;
                default: r_wr_st <= W_IDLE;
            endcase
        end
    end

    // Read channel FSM: address, forward, wait for R, respond.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rd_st  <= R_IDLE;
            r_rsel   <= '0;
            r_ar_off <= '0;
            r_rcnt   <= '0;
            r_rdata  <= '0;
            r_rresp  <= 2'b00;
        end else begin
            case (r_rd_st)
                R_IDLE: if (w_ar_hs) begin
                    r_rsel   <= w_ar_idx;
                    r_ar_off <= w_ar_off;
                    r_rcnt   <= '0;
                    if (w_ar_hit) begin
                        r_rd_st <= R_FWD;
                    end else begin
                        r_rdata <= '0;
                        r_rresp <= 2'b11;
                        r_rd_st <= R_RRSP;
                    end
                end
                R_FWD: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (m_axi_arready[r_rsel]) begin
                        r_rd_st <= R_WAITR;
                    end else if (w_rd_to) begin
                        r_rdata <= '0;
                        r_rresp <= 2'b10;
                        r_rd_st <= R_RRSP;
                    end
                end
                R_WAITR: begin
                    r_rcnt <= r_rcnt + 1'b1;
                    if (m_axi_rvalid[r_rsel]) begin
                        r_rdata <= m_axi_rdata[r_rsel*32 +: 32];
                        r_rresp <= m_axi_rresp[{r_rsel, 1'b0} +: 2];
                        r_rd_st <= R_RRSP;
                    end else if (w_rd_to) begin
                        r_rdata <= '0;
                        r_rresp <= 2'b10;
                        r_rd_st <= R_RRSP;
                    end
                end
                R_RRSP: if (s_axi_rready) r_rd_st <= R_IDLE;
                default: r_rd_st <= R_IDLE;
            endcase
        end
    end

    // Error counters: one step per error response, both channels may step together.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_dec_cnt <= 8'h00;
            r_to_cnt  <= 8'h00;
        end else begin
            r_dec_cnt <= f_sat_add(r_dec_cnt, {1'b0, w_wr_dec} + {1'b0, w_rd_dec});
            r_to_cnt  <= f_sat_add(r_to_cnt,  {1'b0, w_wr_to}  + {1'b0, w_rd_to});
        end
    end

endmodule
`default_nettype wire
